// File: rtl/trap_sequencer_pkg.sv
// Shared trap/CSR types and constants for the machine-mode trap path.
// Cause codes, mstatus layout, interrupt masks and trap FSM states.
package trap_sequencer_pkg;

  localparam logic [31:0] M_INSN_MISALIGN = 32'd0;
  localparam logic [31:0] M_ILL_INSTR     = 32'd2;
  localparam logic [31:0] M_BREAKPOINT    = 32'd3;
  localparam logic [31:0] M_LOAD_AFAULT   = 32'd5;
  localparam logic [31:0] M_STORE_AFAULT  = 32'd7;
  localparam logic [31:0] M_ECALL         = 32'd11;

  localparam logic [31:0] M_SW_INT    = 32'h8000_0003;
  localparam logic [31:0] M_TIMER_INT = 32'h8000_0007;
  localparam logic [31:0] M_EXT_INT   = 32'h8000_000B;

  localparam int MSIP_BIT = 3;
  localparam int MTIP_BIT = 7;
  localparam int MEIP_BIT = 11;

  localparam logic [31:0] SUPPORTED_INTERRUPTS_MASK =
    (32'd1 << MEIP_BIT) | (32'd1 << MTIP_BIT);

  localparam logic [1:0] PRIV_M = 2'b11;

  typedef struct packed {
    logic [18:0] rsvd_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsvd_mid;
    logic        mpie;
    logic [2:0]  rsvd_lo;
    logic        mie;
    logic [2:0]  rsvd_0;
  } mstatus_csr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    JUMP = 2'd2,
    RET  = 2'd3
  } trap_state_t;

endpackage

// File: rtl/trap_sequencer_irq.sv
// Combinational interrupt prioritizer: pending & enabled & supported,
// gated by mstatus.mie; external beats timer.
module irq_prioritizer
  import trap_sequencer_pkg::*;
(
  input  logic        mstatus_mie,
  input  logic [31:0] mip,
  input  logic [31:0] mie,
  output logic        irq_valid,
  output logic [31:0] irq_cause
);

  logic [31:0] pend;

  always_comb begin
    pend      = mip & mie & SUPPORTED_INTERRUPTS_MASK;
    irq_valid = mstatus_mie & (|pend);
    irq_cause = '0;
    if (pend[MEIP_BIT])
      irq_cause = M_EXT_INT;
    else if (pend[MTIP_BIT])
      irq_cause = M_TIMER_INT;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap controller: exception/interrupt entry and MRET,
// driving the CSR trap write port and the fetch redirect.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [31:0] MTVEC_BASE = 32'h8000_0004,
  parameter bit          VECTORED   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic        boundary_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mip_i,
  input  logic [31:0] mepc_i,
  output logic        busy_o,
  output logic        trap_we_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mtval_o,
  output logic        mstatus_we_o,
  output logic [31:0] mstatus_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  trap_state_t  state, state_nx;
  logic [31:0]  cap_cause, cap_pc, cap_tval;
  logic [31:0]  cause_nx, pc_nx, tval_nx;
  logic         irq_valid;
  logic [31:0]  irq_cause;
  logic         take_irq, take_exc, take_ret;
  mstatus_csr_t ms_in, ms_out;
  logic [31:0]  vec_pc;

  irq_prioritizer u_irq (
    .mstatus_mie (mstatus_i[3]),
    .mip         (mip_i),
    .mie         (mie_i),
    .irq_valid   (irq_valid),
    .irq_cause   (irq_cause)
  );

  assign take_irq = irq_valid & boundary_i;
  assign take_exc = exc_valid_i & ~take_irq;
  assign take_ret = mret_i & ~take_irq & ~exc_valid_i;

  always_comb begin
    state_nx = state;
    cause_nx = cap_cause;
    pc_nx    = cap_pc;
    tval_nx  = cap_tval;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          take_irq: begin
            state_nx = SAVE;
            cause_nx = irq_cause;
            pc_nx    = pc_i;
            tval_nx  = '0;
          end
          take_exc: begin
            state_nx = SAVE;
            cause_nx = exc_cause_i;
            pc_nx    = pc_i;
            tval_nx  = exc_tval_i;
          end
          take_ret: state_nx = RET;
          default:  state_nx = IDLE;
        endcase
      end
      SAVE:    state_nx = JUMP;
      JUMP:    state_nx = IDLE;
      RET:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cap_cause <= '0;
      cap_pc    <= '0;
      cap_tval  <= '0;
    end else begin
      state     <= state_nx;
      cap_cause <= cause_nx;
      cap_pc    <= pc_nx;
      cap_tval  <= tval_nx;
    end
  end

  // Only interrupts use the vectored slot; exceptions land on the base.
  assign vec_pc = (VECTORED && cap_cause[31])
                ? MTVEC_BASE + {25'd0, cap_cause[4:0], 2'b00}
                : MTVEC_BASE;

  always_comb begin
    ms_in         = mstatus_csr_t'(mstatus_i);
    ms_out        = ms_in;
    busy_o        = 1'b0;
    trap_we_o     = 1'b0;
    mepc_o        = '0;
    mcause_o      = '0;
    mtval_o       = '0;
    mstatus_we_o  = 1'b0;
    mstatus_o     = '0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    unique case (state)
      IDLE: busy_o = take_irq | exc_valid_i | mret_i;
      SAVE: begin
        busy_o       = 1'b1;
        trap_we_o    = 1'b1;
        mepc_o       = {cap_pc[31:2], 2'b00};
        mcause_o     = cap_cause;
        mtval_o      = cap_tval;
        ms_out.mpie  = ms_in.mie;
        ms_out.mie   = 1'b0;
        ms_out.mpp   = PRIV_M;
        mstatus_we_o = 1'b1;
        mstatus_o    = ms_out;
      end
      JUMP: begin
        busy_o        = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = vec_pc;
      end
      RET: begin
        busy_o        = 1'b1;
        ms_out.mie    = ms_in.mpie;
        ms_out.mpie   = 1'b1;
        ms_out.mpp    = PRIV_M;
        mstatus_we_o  = 1'b1;
        mstatus_o     = ms_out;
        redirect_o    = 1'b1;
        redirect_pc_o = mepc_i;
      end
      default: busy_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: vector table plus scoreboard of expected
// CSR writes and redirects, with reset and ignored-input sequences.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_valid_i = 1'b0;
  logic [31:0] exc_cause_i = '0;
  logic [31:0] exc_tval_i = '0;
  logic        mret_i = 1'b0;
  logic        boundary_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] mstatus_i = '0;
  logic [31:0] mie_i = '0;
  logic [31:0] mip_i = '0;
  logic [31:0] mepc_i = '0;

  logic        busy_o, trap_we_o, mstatus_we_o, redirect_o;
  logic [31:0] mepc_o, mcause_o, mtval_o, mstatus_o, redirect_pc_o;
  logic        v_busy, v_trap_we, v_mstatus_we, v_redirect;
  logic [31:0] v_mepc, v_mcause, v_mtval, v_mstatus, v_redirect_pc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit          exc;
    logic [31:0] cause;
    logic [31:0] tval;
    bit          mret;
    bit          bnd;
    logic [31:0] pc;
    logic [31:0] ms;
    logic [31:0] mie;
    logic [31:0] mip;
    logic [31:0] mepc;
    int          kind;
    logic [31:0] e_mepc;
    logic [31:0] e_mcause;
    logic [31:0] e_mtval;
    logic [31:0] e_ms;
    logic [31:0] e_rpc;
    logic [31:0] e_rpcv;
  } vec_t;

  typedef struct {
    int          acc;
    bit          is_ret;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] ms;
    logic [31:0] rpc;
    logic [31:0] rpcv;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  trap_sequencer #(.MTVEC_BASE(32'h8000_0004), .VECTORED(1'b0)) dut (
    .clk(clk), .rst(rst),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
    .exc_tval_i(exc_tval_i), .mret_i(mret_i),
    .boundary_i(boundary_i), .pc_i(pc_i),
    .mstatus_i(mstatus_i), .mie_i(mie_i), .mip_i(mip_i),
    .mepc_i(mepc_i), .busy_o(busy_o), .trap_we_o(trap_we_o),
    .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o),
    .mstatus_we_o(mstatus_we_o), .mstatus_o(mstatus_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  trap_sequencer #(.MTVEC_BASE(32'h8000_0004), .VECTORED(1'b1)) dut_v (
    .clk(clk), .rst(rst),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
    .exc_tval_i(exc_tval_i), .mret_i(mret_i),
    .boundary_i(boundary_i), .pc_i(pc_i),
    .mstatus_i(mstatus_i), .mie_i(mie_i), .mip_i(mip_i),
    .mepc_i(mepc_i), .busy_o(v_busy), .trap_we_o(v_trap_we),
    .mepc_o(v_mepc), .mcause_o(v_mcause), .mtval_o(v_mtval),
    .mstatus_we_o(v_mstatus_we), .mstatus_o(v_mstatus),
    .redirect_o(v_redirect), .redirect_pc_o(v_redirect_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (!rst && (trap_we_o || mstatus_we_o || redirect_o)) begin
      if (sb.size() == 0) begin
        check("unexpected_event",
              {29'd0, trap_we_o, mstatus_we_o, redirect_o}, 32'd0);
      end else begin
        e = sb[0];
        if (trap_we_o) begin
          check("save_kind", {31'd0, e.is_ret}, 32'd0);
          check("save_cycle", cyc, e.acc + 1);
          check("save_mepc", mepc_o, e.mepc);
          check("save_mcause", mcause_o, e.mcause);
          check("save_mtval", mtval_o, e.mtval);
          check("save_ms_we", {31'd0, mstatus_we_o}, 32'd1);
          check("save_mstatus", mstatus_o, e.ms);
          check("save_no_redir", {31'd0, redirect_o}, 32'd0);
        end else if (redirect_o) begin
          check("redir_cycle", cyc, e.acc + (e.is_ret ? 1 : 2));
          check("redir_pc", redirect_pc_o, e.rpc);
          check("redir_v_pulse", {31'd0, v_redirect}, 32'd1);
          check("redir_v_pc", v_redirect_pc, e.rpcv);
          check("redir_ms_we", {31'd0, mstatus_we_o},
                {31'd0, e.is_ret});
          if (e.is_ret)
            check("ret_mstatus", mstatus_o, e.ms);
          void'(sb.pop_front());
        end else begin
          check("stray_ms_we", {31'd0, mstatus_we_o}, 32'd0);
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    exc_valid_i = v.exc;
    exc_cause_i = v.cause;
    exc_tval_i  = v.tval;
    mret_i      = v.mret;
    boundary_i  = v.bnd;
    pc_i        = v.pc;
    mstatus_i   = v.ms;
    mie_i       = v.mie;
    mip_i       = v.mip;
    mepc_i      = v.mepc;
  endtask

  task automatic quiet();
    exc_valid_i = 1'b0;
    mret_i      = 1'b0;
    boundary_i  = 1'b0;
    mip_i       = '0;
  endtask

  task automatic apply(input vec_t v, input bit noise);
    exp_t x;
    @(posedge clk);
    #1;
    drive(v);
    if (v.kind != 0) begin
      x.acc    = cyc;
      x.is_ret = (v.kind == 2);
      x.mepc   = v.e_mepc;
      x.mcause = v.e_mcause;
      x.mtval  = v.e_mtval;
      x.ms     = v.e_ms;
      x.rpc    = v.e_rpc;
      x.rpcv   = v.e_rpcv;
      sb.push_back(x);
    end
    #1;
    check("busy_accept", {31'd0, busy_o}, {31'd0, v.kind != 0});
    @(posedge clk);
    #1;
    quiet();
    // Inputs raised mid-sequence must be dropped, not queued.
    if (noise && v.kind != 0) begin
      exc_valid_i = 1'b1;
      exc_cause_i = 32'd3;
      mret_i      = 1'b1;
      boundary_i  = 1'b1;
      mip_i       = 32'h880;
      #1;
      check("busy_in_seq", {31'd0, busy_o}, 32'd1);
      if (v.kind == 1) @(posedge clk);
      @(posedge clk);
      #1;
      quiet();
    end
    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_trap_we"}, {31'd0, trap_we_o}, 32'd0);
    check({tag, "_ms_we"}, {31'd0, mstatus_we_o}, 32'd0);
    check({tag, "_redir"}, {31'd0, redirect_o}, 32'd0);
    check({tag, "_data"},
          mepc_o | mcause_o | mtval_o | mstatus_o | redirect_pc_o, 32'd0);
    check({tag, "_v_any"},
          {31'd0, v_busy | v_trap_we | v_mstatus_we | v_redirect}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 'd2, 'hFFFF, 1'b0, 1'b0, 'h8000_0100, 'h8, 'h0,
                 'h0, 'h0, 1, 'h8000_0100, 'd2, 'hFFFF, 'h1880,
                 'h8000_0004, 'h8000_0004};
    vecs[1]  = '{1'b0, 'd0, 'h0, 1'b0, 1'b1, 'h8000_0200, 'h8, 'h80,
                 'h80, 'h0, 1, 'h8000_0200, 'h8000_0007, 'h0, 'h1880,
                 'h8000_0004, 'h8000_0020};
    vecs[2]  = '{1'b1, 'd11, 'h1234, 1'b0, 1'b1, 'h8000_0300, 'h8, 'h880,
                 'h880, 'h0, 1, 'h8000_0300, 'h8000_000B, 'h0, 'h1880,
                 'h8000_0004, 'h8000_0030};
    vecs[3]  = '{1'b0, 'd0, 'h0, 1'b0, 1'b1, 'h8000_0400, 'h0, 'h800,
                 'h800, 'h0, 0, 'h0, 'h0, 'h0, 'h0, 'h0, 'h0};
    vecs[4]  = '{1'b0, 'd0, 'h0, 1'b0, 1'b0, 'h8000_0400, 'h8, 'h800,
                 'h800, 'h0, 0, 'h0, 'h0, 'h0, 'h0, 'h0, 'h0};
    vecs[5]  = '{1'b0, 'd0, 'h0, 1'b1, 1'b0, 'h0, 'h80, 'h0,
                 'h0, 'h8000_0104, 2, 'h0, 'h0, 'h0, 'h1888,
                 'h8000_0104, 'h8000_0104};
    vecs[6]  = '{1'b1, 'd5, 'hDEAD, 1'b0, 1'b0, 'h8000_0402, 'h6000, 'h0,
                 'h0, 'h0, 1, 'h8000_0400, 'd5, 'hDEAD, 'h7800,
                 'h8000_0004, 'h8000_0004};
    vecs[7]  = '{1'b1, 'd11, 'h0, 1'b0, 1'b0, 'h8000_0500, 'h8, 'h80,
                 'h80, 'h0, 1, 'h8000_0500, 'd11, 'h0, 'h1880,
                 'h8000_0004, 'h8000_0004};
    vecs[8]  = '{1'b0, 'd0, 'h0, 1'b1, 1'b1, 'h0, 'h6008, 'h0,
                 'h0, 'h8000_0010, 2, 'h0, 'h0, 'h0, 'h7880,
                 'h8000_0010, 'h8000_0010};
    vecs[9]  = '{1'b0, 'd0, 'h0, 1'b0, 1'b1, 'h8000_0600, 'h8, 'h8,
                 'h8, 'h0, 0, 'h0, 'h0, 'h0, 'h0, 'h0, 'h0};
    vecs[10] = '{1'b1, 'd3, 'h8000_0700, 1'b1, 1'b0, 'h8000_0700, 'h88,
                 'h0, 'h0, 'h1234_5678, 1, 'h8000_0700, 'd3, 'h8000_0700,
                 'h1880, 'h8000_0004, 'h8000_0004};
    vecs[11] = '{1'b0, 'd0, 'h0, 1'b0, 1'b1, 'h8000_0800, 'h1888, 'h800,
                 'h800, 'h0, 1, 'h8000_0800, 'h8000_000B, 'h0, 'h1880,
                 'h8000_0004, 'h8000_0030};

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      apply(vecs[i], i[0]);

    // Reset landing in SAVE must kill the write and the redirect.
    @(posedge clk);
    #1;
    drive(vecs[0]);
    @(posedge clk);
    #1;
    quiet();
    check("rst_pre_save", {31'd0, trap_we_o}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_after_busy", {31'd0, busy_o}, 32'd0);

    apply(vecs[0], 1'b0);
    apply(vecs[1], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=%0d required=<20000 cycles", cyc);
    $fatal(1, "timeout");
  end

endmodule
